// File: rtl/fir_scheduler_pkg.sv
// Shared types and default sizing for the FIR run scheduler.
// Optional feature macro: FIR_BYPASS_ON_LOCK_EN (see fir_scheduler.sv).
package fir_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } stateT;

  localparam int DefDataWidth     = 12;
  localparam int DefTimeoutCycles = 64;
  localparam int DefCountWidth    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for debug event counts; sticks at all-ones.
module sat_counter #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [Width-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/fir_scheduler.sv
// Sequences one FIR run per ADC sample with a 1-deep pending slot, a done
// timeout with unfiltered fallback, and saturating overrun/timeout counters.
// Define FIR_BYPASS_ON_LOCK_EN to pass samples through unfiltered while the
// coefficient lock is held instead of holding them.
module fir_scheduler
  import fir_scheduler_pkg::*;
#(
  parameter int DataWidth     = DefDataWidth,
  parameter int TimeoutCycles = DefTimeoutCycles,
  parameter int CountWidth    = DefCountWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DataWidth-1:0]  inData,
  input  logic                  inValid,
  input  logic                  lock,
  output logic                  firStart,
  output logic [DataWidth-1:0]  firX,
  input  logic                  firDone,
  input  logic [DataWidth-1:0]  firY,
  output logic [DataWidth-1:0]  outData,
  output logic                  outValid,
  output logic                  busy,
  output logic [CountWidth-1:0] overrunCount,
  output logic [CountWidth-1:0] timeoutCount
);

  localparam int TimerWidth = $clog2(TimeoutCycles);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  stateT state, stateNext;

  logic                  pendValid;
  logic [DataWidth-1:0]  pendData;
  logic [DataWidth-1:0]  runX;
  logic [TimerWidth-1:0] timer;

  logic startRun;
  logic emitRaw;
  logic runDone;
  logic runTimeout;
  logic consume;
  logic overrunInc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    stateNext  = state;
    startRun   = 1'b0;
    emitRaw    = 1'b0;
    runDone    = 1'b0;
    runTimeout = 1'b0;
    unique case (state)
      IDLE, HOLD: begin
        if (pendValid) begin
          if (!lock) begin
            startRun  = 1'b1;
            stateNext = RUN;
          end
`ifdef FIR_BYPASS_ON_LOCK_EN
          // Skip a cycle after any output pulse so outValid never runs back-to-back.
          else if (!outValid) begin
            emitRaw   = 1'b1;
            stateNext = IDLE;
          end
`else
          else begin
            stateNext = HOLD;
          end
`endif
        end
      end
      RUN: begin
        // firDone has priority over a timeout landing on the same cycle.
        if (firDone) begin
          runDone   = 1'b1;
          stateNext = IDLE;
        end else if (timer == TimerLast) begin
          runTimeout = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign consume = startRun | emitRaw;

`ifdef FIR_BYPASS_ON_LOCK_EN
  // Samples that will be passed straight through are not overrun victims.
  assign overrunInc = inValid & pendValid & ~consume & ((state == RUN) | ~lock);
`else
  assign overrunInc = inValid & pendValid & ~consume;
`endif

  assign firStart = startRun;
  assign firX     = startRun ? pendData : runX;
  assign busy     = (state != IDLE) || pendValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pendValid <= 1'b0;
      pendData  <= '0;
      runX      <= '0;
      timer     <= '0;
      outData   <= '0;
      outValid  <= 1'b0;
    end else begin
      outValid <= runDone | runTimeout | emitRaw;
      if (runDone) begin
        outData <= firY;
      end else if (runTimeout) begin
        outData <= runX;
      end else if (emitRaw) begin
        outData <= pendData;
      end

      if (startRun) begin
        runX  <= pendData;
        timer <= '0;
      end else if (state == RUN) begin
        timer <= timer + TimerWidth'(1);
      end

      // A new sample always lands in pending, even in the cycle it is consumed.
      if (inValid) begin
        pendValid <= 1'b1;
        pendData  <= inData;
      end else if (consume) begin
        pendValid <= 1'b0;
      end
    end
  end

  sat_counter #(.Width(CountWidth)) u_overrun (
    .clk   (clk),
    .reset (reset),
    .inc   (overrunInc),
    .count (overrunCount)
  );

  sat_counter #(.Width(CountWidth)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .inc   (runTimeout),
    .count (timeoutCount)
  );

endmodule

// File: tb/tb_fir_scheduler.sv
// Self-checking bench for fir_scheduler: directed tables/sequences plus a
// randomized run against a cycle-counting reference model.
module tb_fir_scheduler;

  localparam int DW = 12;
  localparam int T  = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inValid = 1'b0;
  logic [DW-1:0] inData = '0;
  logic          lock = 1'b0;
  logic          firDone = 1'b0;
  logic [DW-1:0] firY = '0;
  logic          firStart;
  logic [DW-1:0] firX;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          busy;
  logic [CW-1:0] overrunCount;
  logic [CW-1:0] timeoutCount;

  always #5 clk = ~clk;

  fir_scheduler #(
    .DataWidth(DW), .TimeoutCycles(T), .CountWidth(CW)
  ) dut (
    .clk(clk), .reset(reset), .inData(inData), .inValid(inValid), .lock(lock),
    .firStart(firStart), .firX(firX), .firDone(firDone), .firY(firY),
    .outData(outData), .outValid(outValid), .busy(busy),
    .overrunCount(overrunCount), .timeoutCount(timeoutCount)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a queue for pending, a run start stamp for the timeout.
  logic [DW-1:0] mPend[$];
  bit            mRun;
  int            mStart;
  logic [DW-1:0] mX;
  bit            mOutV;
  logic [DW-1:0] mOutD;
  int            mOver;
  int            mTo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelClear();
    mPend.delete();
    mRun  = 0;
    mX    = '0;
    mOutV = 0;
    mOutD = '0;
    mOver = 0;
    mTo   = 0;
  endtask

  task automatic modelCheck();
    bit expStart;
    expStart = !mRun && (mPend.size() > 0) && !lock;
    check("firStart", firStart, expStart);
    if (expStart) check("firX at start", firX, mPend[0]);
    else if (mRun) check("firX during run", firX, mX);
    check("outValid", outValid, mOutV);
    check("outData", outData, mOutD);
    check("busy", busy, mRun || (mPend.size() > 0));
    check("overrunCount", overrunCount, mOver);
    check("timeoutCount", timeoutCount, mTo);
  endtask

  task automatic modelStep();
    bit            wasRun;
    bit            nOv;
    bit            countIt;
    logic [DW-1:0] nOd;
    wasRun = mRun;
    nOv    = 0;
    nOd    = mOutD;
    if (mRun) begin
      if (firDone) begin
        nOv = 1; nOd = firY; mRun = 0;
      end else if (cyc - mStart == T) begin
        nOv = 1; nOd = mX; mRun = 0;
        if (mTo < 255) mTo++;
      end
    end else if (mPend.size() > 0) begin
      if (!lock) begin
        mRun = 1; mStart = cyc; mX = mPend.pop_front();
      end
`ifdef FIR_BYPASS_ON_LOCK_EN
      else if (!mOutV) begin
        nOv = 1; nOd = mPend.pop_front();
      end
`endif
    end
    if (inValid) begin
      if (mPend.size() > 0) begin
        void'(mPend.pop_front());
        countIt = 1;
`ifdef FIR_BYPASS_ON_LOCK_EN
        countIt = wasRun || !lock;
`endif
        if (countIt && mOver < 255) mOver++;
      end
      mPend.push_back(inData);
    end
    mOutV = nOv;
    mOutD = nOd;
    cyc++;
  endtask

  // Inputs are driven at the falling edge; outputs sampled 1 time unit later.
  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic lk,
                      input logic dn, input logic [DW-1:0] y);
    inValid = iv; inData = d; lock = lk; firDone = dn; firY = y;
    #1;
    modelCheck();
  endtask

  task automatic advance();
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    inValid = 1'b0; lock = 1'b0; firDone = 1'b0; inData = '0; firY = '0;
    @(negedge clk);
    reset = 1'b0;
    modelClear();
    cyc++;
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          dn;
    logic [DW-1:0] y;
    logic          eStart;
    logic [DW-1:0] eX;
    logic          eOv;
    logic [DW-1:0] eOut;
    logic          eBusy;
  } vecT;

  vecT tbl[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sC, oC, nS, nO, k;
    int eS[3];
    logic [DW-1:0] eX3[3];
    logic [DW-1:0] eY3[3];
    bit lk, dn;

    @(negedge clk);
    doReset();

    // Reset state
    tick(0, '0, 0, 0, '0);
    check("reset firStart", firStart, 0);
    check("reset firX", firX, 0);
    check("reset outData", outData, 0);
    check("reset outValid", outValid, 0);
    check("reset busy", busy, 0);
    check("reset overrunCount", overrunCount, 0);
    check("reset timeoutCount", timeoutCount, 0);
    advance();

    // Basic latency, fir latency 10: inValid@5 -> start@6 -> done@16 -> out@17
    doReset();
    for (int i = 0; i < 20; i++) begin
      tbl[i].iv     = (i == 5);
      tbl[i].d      = 12'h123;
      tbl[i].dn     = (i == 16);
      tbl[i].y      = 12'h456;
      tbl[i].eStart = (i == 6);
      tbl[i].eX     = 12'h123;
      tbl[i].eOv    = (i == 17);
      tbl[i].eOut   = (i >= 17) ? 12'h456 : 12'h000;
      tbl[i].eBusy  = (i >= 6) && (i <= 16);
    end
    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].iv, tbl[i].d, 0, tbl[i].dn, tbl[i].y);
      check("tbl firStart", firStart, tbl[i].eStart);
      if (tbl[i].eStart) check("tbl firX", firX, tbl[i].eX);
      check("tbl outValid", outValid, tbl[i].eOv);
      check("tbl outData", outData, tbl[i].eOut);
      check("tbl busy", busy, tbl[i].eBusy);
      advance();
    end

    // Lock held 0..40 with a sample at 5
    doReset();
    nS = 0; nO = 0;
    for (int i = 0; i < 46; i++) begin
      tick(i == 5, 12'h0A0, i <= 40, 0, '0);
`ifdef FIR_BYPASS_ON_LOCK_EN
      if (outValid) begin
        check("bypass out cycle", i, 7);
        check("bypass out data", outData, 12'h0A0);
        nO++;
      end
      if (firStart) nS++;
`else
      if (i == 20) check("lock busy", busy, 1);
      if (firStart) begin
        check("lock start cycle", i, 41);
        check("lock firX", firX, 12'h0A0);
        nS++;
      end
`endif
      advance();
    end
`ifdef FIR_BYPASS_ON_LOCK_EN
    check("bypass start count", nS, 0);
    check("bypass out count", nO, 1);
`else
    check("lock start count", nS, 1);
`endif

    // Overruns under lock, then release
    doReset();
    nO = 0;
    for (int i = 0; i < 13; i++) begin
      tick(i == 2 || i == 4 || i == 6, 12'(i / 2), i < 10, 0, '0);
      if (outValid) nO++;
`ifdef FIR_BYPASS_ON_LOCK_EN
      if (i == 9) check("bypass overrunCount", overrunCount, 0);
`else
      if (i == 9) check("overrunCount 3 samples", overrunCount, 2);
      if (i == 10) begin
        check("release firStart", firStart, 1);
        check("release firX", firX, 12'h003);
      end
`endif
      advance();
    end
`ifdef FIR_BYPASS_ON_LOCK_EN
    check("bypass out count 3", nO, 3);
`else
    check("no out during lock", nO, 0);
`endif

    // Overrun saturation
    doReset();
    for (int i = 0; i < 305; i++) begin
      tick(1, 12'($urandom), 1, 0, '0);
      advance();
    end
    tick(0, '0, 1, 0, '0);
`ifdef FIR_BYPASS_ON_LOCK_EN
    check("bypass sat overrunCount", overrunCount, 0);
`else
    check("sat overrunCount", overrunCount, 255);
`endif
    advance();

    // Timeout: fir never answers
    doReset();
    sC = -1; oC = -1;
    for (int i = 0; i < 90; i++) begin
      tick(i == 0, 12'h7FF, 0, 0, '0);
      if (firStart && sC < 0) sC = i;
      if (outValid && oC < 0) begin
        oC = i;
        check("timeout outData", outData, 12'h7FF);
      end
      advance();
    end
    check("timeout latency", oC - sC, T + 1);
    check("timeoutCount 1", timeoutCount, 1);

    // Done and timeout on the same cycle: done wins
    sC = -1; oC = -1;
    for (int i = 0; i < 90; i++) begin
      dn = (sC >= 0) && (i == sC + T);
      tick(i == 0, 12'h2AA, 0, dn, 12'h155);
      if (firStart && sC < 0) sC = i;
      if (outValid && oC < 0) begin
        oC = i;
        check("tie outData", outData, 12'h155);
      end
      advance();
    end
    check("tie latency", oC - sC, T + 1);
    check("tie timeoutCount", timeoutCount, 1);

    // Reset mid-run with a late done
    for (int i = 0; i < 4; i++) begin
      tick(i == 0, 12'h5A5, 0, 0, '0);
      advance();
    end
    doReset();
    for (int j = 0; j < 10; j++) begin
      tick(0, '0, 0, j == 2, 12'h777);
      check("post-reset outValid", outValid, 0);
      advance();
    end
    tick(0, '0, 0, 0, '0);
    check("post-reset firX", firX, 0);
    check("post-reset outData", outData, 0);
    check("post-reset busy", busy, 0);
    check("post-reset timeoutCount", timeoutCount, 0);
    check("post-reset overrunCount", overrunCount, 0);
    advance();

    // Back-to-back with a sample arriving in the consume cycle
    doReset();
    eS  = '{1, 6, 9};
    eX3 = '{12'h111, 12'h222, 12'h333};
    eY3 = '{12'hA01, 12'hA02, 12'hA03};
    nS = 0; nO = 0;
    for (int i = 0; i < 16; i++) begin
      k = (i == 5) ? 0 : (i == 8) ? 1 : 2;
      tick(i == 0 || i == 3 || i == 6, (i == 0) ? 12'h111 : (i == 3) ? 12'h222 : 12'h333,
           0, i == 5 || i == 8 || i == 11, eY3[k]);
      if (firStart) begin
        if (nS < 3) begin
          check("b2b start cycle", i, eS[nS]);
          check("b2b firX", firX, eX3[nS]);
        end
        nS++;
      end
      if (outValid) begin
        if (nO < 3) check("b2b outData", outData, eY3[nO]);
        nO++;
      end
      advance();
    end
    check("b2b start count", nS, 3);
    check("b2b out count", nO, 3);
    check("b2b overrunCount", overrunCount, 0);

    // Randomized traffic against the model
    doReset();
    lk = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(29) == 0) lk = ~lk;
      if ($urandom_range(699) == 0) begin
        doReset();
      end else begin
        if (((i / 500) % 2) == 0) dn = ($urandom_range(7) == 0);
        else dn = ($urandom_range(99) == 0);
        tick($urandom_range(4) == 0, 12'($urandom), lk, dn, 12'($urandom));
        advance();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_scheduler.md
Name: fir_scheduler

Overview:
Sits between the I2S controller's ADC sample stream and the fir engine. It sequences one FIR run per incoming sample and holds a 1-deep pending sample while the coefficient lock (SPI write in progress) is active. It guards the engine with a done-timeout that falls back to an unfiltered sample, and returns filtered samples to the DAC path as single-cycle valid pulses. Overrun and timeout events are counted for debug readout.

Parameters:
DataWidth, 12, sample width in and out
TimeoutCycles, 64, max cycles from firStart to firDone before fallback (must be >= 2)
CountWidth, 8, width of saturating event counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
inData  input  DataWidth  ADC sample (signed two's complement, passed opaquely)
inValid  input  1  1-cycle strobe, inData valid
lock  input  1  high = coefficients being written; no new FIR start
firStart  output  1  1-cycle start pulse to fir
firX  output  DataWidth  sample to fir; stable from firStart until firDone or timeout
firDone  input  1  fir completion strobe
firY  input  DataWidth  fir result, valid with firDone
outData  output  DataWidth  sample toward DAC path
outValid  output  1  1-cycle strobe, outData valid
busy  output  1  high when state != IDLE or pending sample held
overrunCount  output  CountWidth  saturating count of overwritten pending samples
timeoutCount  output  CountWidth  saturating count of FIR timeouts

Behaviour:
- Clock: single clock clk. Reset: synchronous, active-high reset. All state updates on rising clk.
- Reset values: firStart=0, firX=0, outData=0, outValid=0, busy=0, both counters=0, pending empty, state=IDLE, timeout counter=0.
- Reset mid-run discards the active and pending samples. It does not wait for firDone; a late firDone after reset is ignored.
- Pending register: 1-deep. inValid captures inData into pending at the clock edge.
- Overrun: if pending is full and not being consumed in the same cycle, inValid overwrites it with the newest sample and increments overrunCount (saturating at all-ones).
- Simultaneous consume and inValid: the new sample enters pending with no overrun.
- States:
  - IDLE: if pending and !lock, assert firStart for 1 cycle, load firX from pending, clear pending, go RUN. If pending and lock, go HOLD.
  - HOLD: wait for !lock, then behave as IDLE's start path in the cycle lock is sampled low.
  - RUN: the timeout counter starts at 0 in the firStart cycle and increments each cycle.
    - firDone=1: outData<=firY, outValid=1 next cycle, go IDLE.
    - Counter reaches TimeoutCycles-1 without firDone: outData<=firX (unfiltered fallback), outValid=1 next cycle, timeoutCount++ (saturating), go IDLE.
    - firDone and timeout in the same cycle: firDone wins, no count.
- lock rising during RUN does not abort the run.
- firDone sampled outside RUN is ignored.
- Latency (no lock, fir latency L cycles from start to done):
  - inValid at cycle n → firStart at cycle n+1.
  - firDone at n+1+L → outValid at n+2+L.
- Back-to-back: from RUN→IDLE, a held pending sample starts in the next cycle. Minimum gap between firStart pulses is 2 cycles.
- outValid is never high for 2 consecutive cycles.

Optional Feature:
FIR_BYPASS_ON_LOCK_EN
- Defined: while lock=1 in IDLE/HOLD, a pending sample is not held. It is emitted unfiltered as outData with outValid in the cycle after capture, so audio continues during SPI writes. No firStart is issued and no overrun counting applies to these samples. Samples accepted during RUN still wait for RUN to end.
- Undefined: HOLD behaviour as above; a sample held through lock may be overwritten (counted as overrun).

Decomposition:
- Package fir_scheduler_pkg:
  - state enum {IDLE, HOLD, RUN}, 2 bits
  - default localparams for DataWidth/TimeoutCycles/CountWidth
- Sub-module sat_counter (parameter Width; inputs clk, reset, inc; output count, saturating). Instanced twice for overrunCount and timeoutCount.

Test Plan:
- No lock, fir model L=10, inValid with inData=0x123 at cycle 5 → firStart at 6, firX=0x123; fir returns firY=0x456 at cycle 16 → outValid with outData=0x456 at cycle 17, busy low from cycle 17.
- lock=1 from cycle 0–40, inValid 0x0A0 at cycle 5 → no firStart, busy=1; lock low sampled at 41 → firStart at 41, firX=0x0A0. With FIR_BYPASS_ON_LOCK_EN instead → outValid with outData=0x0A0 at cycle 7 and no firStart.
- lock held, three inValid (0x001, 0x002, 0x003) → overrunCount=2, firX=0x003 on release. Saturation: 300 overruns at CountWidth=8 → overrunCount=255.
- fir model never asserts done, inData=0x7FF → outValid with outData=0x7FF exactly TimeoutCycles+1 cycles after firStart, timeoutCount=1. Done and timeout on the same cycle → outData=firY, timeoutCount unchanged.
- inValid during RUN plus a second inValid in the consume cycle → no overrun, both samples filtered in order, firStart pulses 2+ cycles apart.
- reset asserted mid-RUN, late firDone 3 cycles later → no outValid, all outputs at reset values, counters 0.
